compare_sequencer: RTL
======================

Name: compare_sequencer

Overview:
Sequential front end for the 4-bit comparison units (greater / less-than / equal / max). It captures two operands from a shared switch bus on successive button presses and drives them to the combinational comparators. It then registers the comparator verdicts and max value for display, with a done pulse, a comparison counter and a sticky consistency-error flag. It sits between the board inputs and the comparators, and between the comparators and the display logic.

Parameters:
W, 4, operand width; must match the comparator operand width.
CNT_W, 8, width of the completed-comparison counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  W  operand switch bus; must be stable while load is high
load  input  1  asynchronous pushbutton, active-high level
clear  input  1  synchronous clear, active-high, already synchronous to clk
x_out  output  W  registered operand A, to comparator x input
y_out  output  W  registered operand B, to comparator y input
gt_in  input  1  comparator result x>y
lt_in  input  1  comparator result x<y
eq_in  input  1  comparator result x==y
max_in  input  W  comparator max(x,y)
gt_q  output  1  registered x>y
lt_q  output  1  registered x<y
eq_q  output  1  registered x==y
max_q  output  W  registered max
done  output  1  one-cycle pulse, results just captured
state  output  2  current FSM state
cmp_count  output  CNT_W  number of completed comparisons
err  output  1  sticky flag: comparator inputs not one-hot

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: state=IDLE(00); x_out, y_out, max_q, cmp_count, gt_q, lt_q, eq_q, done and err all 0.
  - Internal: synchroniser flops and edge-detect flop cleared.
  - Reset mid-operation aborts any capture. No pulse is generated from a load already high at reset release until load goes low then high again.
- load path:
  - 2-flop synchroniser (s1, s2), then a previous-value flop; ld_pulse = s2 & ~prev.
  - load first sampled high at edge k gives ld_pulse high between edges k+1 and k+2. Operand is captured at edge k+2.
  - Holding load high yields exactly one pulse.
- States: IDLE=00, WAIT_B=01, CMP=10, SHOW=11.
  - IDLE: ld_pulse -> x_out<=din, go WAIT_B.
  - WAIT_B: ld_pulse -> y_out<=din, go CMP.
  - CMP (exactly one cycle): comparators see stable x_out/y_out. At the exiting edge:
    - gt_q/lt_q/eq_q/max_q <= gt_in/lt_in/eq_in/max_in.
    - done<=1 and cmp_count<=cmp_count+1, wrapping modulo 2^CNT_W.
    - err<=1 if {gt_in,lt_in,eq_in} is not exactly one-hot; err is never cleared except by reset or clear.
    - Go SHOW.
  - SHOW: results held. ld_pulse -> x_out<=din, y_out unchanged, result registers unchanged, go WAIT_B.
- done: high only during the first SHOW cycle; 0 in every other cycle.
- Results: gt_q/lt_q/eq_q/max_q change only at CMP exit, clear, or reset. They stay valid through WAIT_B until the next CMP.
- clear: synchronous, highest priority over ld_pulse in every state. Next state is IDLE, and all registered outputs except state go to their reset values. The synchroniser is not cleared, so a load held across clear produces no new pulse.
- ld_pulse in CMP is ignored and not queued. It cannot occur back-to-back in practice because the edge detect needs load low in between.
- No arithmetic beyond the counter increment; no other wrap cases.

Test Plan:
1. Reset then A=0x9, B=0x3 (load pulses, din stable): x_out=9, y_out=3; one cycle after CMP, gt_q=1, lt_q=0, eq_q=0, max_q=9, done pulses once, cmp_count=1, state=SHOW.
2. From SHOW, load A=0x5 then B=0x5: eq_q=1, max_q=5, cmp_count=2. Verify results from step 1 persist through WAIT_B until CMP exit.
3. Hold load high for 20 cycles in IDLE with din=0xA: exactly one ld_pulse, x_out=A, state=WAIT_B and not CMP. Check the 2-cycle capture latency: din changed at edge k+3 is not captured.
4. Stub comparator driving gt_in=1, eq_in=1 during CMP: err=1 and stays 1 across further good comparisons. Pulse clear: err=0, all outputs 0, state=IDLE.
5. Run 256 comparisons with CNT_W=8: cmp_count wraps 255->0, with done pulsed exactly 256 times.
6. Assert rst_n low during WAIT_B with load held high: all outputs 0 immediately (asynchronous). After release, no capture until load goes low then high again.

Source files
------------

// File: rtl/compare_sequencer.sv
// compare_sequencer: captures two operands from a shared switch bus on
// successive load presses, presents them to external comparators, and
// registers the comparator verdicts with a done pulse, a completed-comparison
// counter and a sticky consistency-error flag.
module compare_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic             load,
  input  logic             clear,
  output logic [W-1:0]     x_out,
  output logic [W-1:0]     y_out,
  input  logic             gt_in,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic [W-1:0]     max_in,
  output logic             gt_q,
  output logic             lt_q,
  output logic             eq_q,
  output logic [W-1:0]     max_q,
  output logic             done,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cmp_count,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT_B = 2'b01,
    CMP    = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t state_q, state_next;

  // Load synchroniser and edge detector.
  logic       s1, s2, prev;
  // warm shifts in ones after reset release; once s2 reflects the real load
  // level (warm[1]) and has been seen low, the edge detector is armed. This
  // keeps a load that was already high at reset release from firing a pulse.
  logic [1:0] warm;
  logic       armed;
  logic       ld_pulse;

  logic [W-1:0]     x_next, y_next, max_next;
  logic             gt_next, lt_next, eq_next, done_next, err_next;
  logic [CNT_W-1:0] cnt_next;
  logic             verdict_ok;

  assign ld_pulse = s2 & ~prev & armed;

  // Synchronise the asynchronous pushbutton and track its previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1    <= load;
      s2    <= s1;
      prev  <= s2;
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & ~s2);
    end
  end

  // Exactly one of the three verdicts must be asserted.
  always_comb begin
    verdict_ok = 1'b0;
    case ({gt_in, lt_in, eq_in})
      3'b100, 3'b010, 3'b001: verdict_ok = 1'b1;
      default:                verdict_ok = 1'b0;
    endcase
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_out     <= '0;
      y_out     <= '0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      max_q     <= '0;
      done      <= 1'b0;
      cmp_count <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_next;
      x_out     <= x_next;
      y_out     <= y_next;
      gt_q      <= gt_next;
      lt_q      <= lt_next;
      eq_q      <= eq_next;
      max_q     <= max_next;
      done      <= done_next;
      cmp_count <= cnt_next;
      err       <= err_next;
    end
  end

  // Next-state and next-output logic; clear overrides everything.
  always_comb begin
    state_next = state_q;
    x_next     = x_out;
    y_next     = y_out;
    gt_next    = gt_q;
    lt_next    = lt_q;
    eq_next    = eq_q;
    max_next   = max_q;
    done_next  = 1'b0;
    cnt_next   = cmp_count;
    err_next   = err;
    if (clear) begin
      state_next = IDLE;
      x_next     = '0;
      y_next     = '0;
      gt_next    = 1'b0;
      lt_next    = 1'b0;
      eq_next    = 1'b0;
      max_next   = '0;
      cnt_next   = '0;
      err_next   = 1'b0;
    end else begin
      case (state_q)
        IDLE, SHOW: begin
          if (ld_pulse) begin
            x_next     = din;
            state_next = WAIT_B;
          end
        end
        WAIT_B: begin
          if (ld_pulse) begin
            y_next     = din;
            state_next = CMP;
          end
        end
        CMP: begin
          // Comparators have had a full cycle of stable operands.
          gt_next    = gt_in;
          lt_next    = lt_in;
          eq_next    = eq_in;
          max_next   = max_in;
          done_next  = 1'b1;
          cnt_next   = cmp_count + CNT_W'(1);
          err_next   = err | ~verdict_ok;
          state_next = SHOW;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign state = state_q;

endmodule
